tm_controller: RTL and testbench
================================

TM_CONTROLLER -- requirements
Module: tm_controller

Interface
REQ-001 Parameter NUM_STATES, default 4, number of machine states; legal state codes 0..NUM_STATES-1.
REQ-002 Parameter TAPE_LEN, default 64, tape cells; head and address width AW = clog2(TAPE_LEN).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high (ports clock, reset).
REQ-004 clock  input  1  system clock, all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 input_data  input  4  rule field value captured on each load step.
REQ-007 Next  input  1  level button; its rising edge is the step request.
REQ-008 Done  input  1  level; ends rule loading.
REQ-009 tape_rdata  input  1  combinational read of the external tape cell at tape_addr.
REQ-010 tape_addr  output  AW  tape address (head position except during CLEAR).
REQ-011 tape_we  output  1  one-cycle tape write strobe.
REQ-012 tape_wdata  output  1  symbol to write.
REQ-013 cur_state  output  clog2(NUM_STATES)  current machine state.
REQ-014 head_pos  output  AW  current head position.
REQ-015 busy  output  1  high in CLEAR, READ, EXEC.
REQ-016 Compute_done  output  1  machine has halted.

Function
REQ-017 Rule table: 2*NUM_STATES internal entries indexed {state, symbol}; each entry = write_sym (1b), move (1b: 0=left, 1=right), next_state (4b).
REQ-018 Step request = Next high while previous-cycle Next low (registered edge detect); held Next yields exactly one request.
REQ-019 FSM states: LOAD, CLEAR, RUN, READ, EXEC, HALT; reset enters LOAD.
REQ-020 LOAD: each step request writes input_data into field index f of entry e (f order: write_sym=bit0, move=bit0, next_state=all 4 bits); f increments 0..2, then f=0, e increments.
REQ-021 LOAD: after field 2 of entry 2*NUM_STATES-1, further step requests are ignored until Done.
REQ-022 LOAD: Done high for one cycle -> CLEAR next cycle; Done and step request in the same cycle: Done wins, input_data discarded.
REQ-023 Unloaded entries keep reset value: write_sym 0, move 0, next_state 4'hF (halt).
REQ-024 CLEAR: tape_we=1, tape_wdata=0, tape_addr counting 0..TAPE_LEN-1, one cell per cycle (TAPE_LEN cycles), then RUN with head_pos=0, cur_state=0.
REQ-025 RUN: step request -> READ next cycle; Done ignored.
REQ-026 READ (1 cycle): tape_addr=head_pos, tape_rdata sampled into symbol register.
REQ-027 EXEC (1 cycle): tape_we=1, tape_wdata=write_sym of entry {cur_state, symbol}, tape_addr=head_pos; at cycle end head_pos and cur_state update.
REQ-028 Step latency: request sampled at edge t -> READ in t+1 -> EXEC in t+2 -> new head_pos/cur_state visible after edge t+3.
REQ-029 Head move: right = (head_pos+1) mod TAPE_LEN; left = (head_pos-1) mod TAPE_LEN (0 wraps to TAPE_LEN-1).
REQ-030 Halt: if selected next_state >= NUM_STATES, EXEC still writes and moves, cur_state holds, FSM enters HALT, Compute_done=1.
REQ-031 HALT: step requests and Done ignored; outputs frozen until reset.
REQ-032 Step requests during CLEAR, READ, EXEC SHALL be dropped, not queued.
REQ-033 tape_we SHALL be 0 in LOAD, RUN, READ, HALT.

Reset
REQ-034 Reset, including mid-CLEAR or mid-step, returns to LOAD within one cycle: all rule entries to REQ-023 values, e=f=0, edge-detect register 0.
REQ-035 Reset values: tape_addr 0, tape_we 0, tape_wdata 0, cur_state 0, head_pos 0, busy 0, Compute_done 0.

Verification
REQ-036 Reset asserted 2 cycles -> all outputs per REQ-035, Next pulses after Done produce CLEAR of exactly 64 tape_we cycles.
REQ-037 Load entry0 = {1,1,0}, Done, 3 steps -> tape cells 0,1,2 written 1, head_pos 3, cur_state 0, Compute_done 0.
REQ-038 Load entry0 = {1,0,1}, entry2(state1,sym0) = {0,1,4'hF}, Done, 2 steps -> head 63 then 0, Compute_done 1, further Next no change.
REQ-039 Next held high 10 cycles in RUN -> exactly one READ/EXEC pair; Next pulse during EXEC -> ignored.
REQ-040 Done and Next rising together in LOAD -> no field captured, CLEAR begins next cycle.
REQ-041 Reset at CLEAR cycle 20 -> LOAD next cycle, tape_we 0, rule table at default values.

Source files
------------

// File: rtl/tm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tm_controller
//  Description : Single-tape Turing machine sequencer. Rules are entered one
//                field per Next press, the external tape is zeroed, then each
//                Next press performs one read / write / move step until a
//                halt state is selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm_controller #(
  parameter  int NUM_STATES = 4,
  parameter  int TAPE_LEN   = 64,
  localparam int AW         = $clog2(TAPE_LEN),
  localparam int SW         = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    input_data,
  input  logic          Next,
  input  logic          Done,
  input  logic          tape_rdata,
  output logic [AW-1:0] tape_addr,
  output logic          tape_we,
  output logic          tape_wdata,
  output logic [SW-1:0] cur_state,
  output logic [AW-1:0] head_pos,
  output logic          busy,
  output logic          Compute_done
);

  localparam int          NE       = 2 * NUM_STATES;
  localparam int          EW       = SW + 1;
  // Rule entry layout: [5] write_sym, [4] move (1 = right), [3:0] next_state
  localparam logic [5:0]  RULE_RST = 6'b00_1111;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_READ  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    rules_q [NE];
  logic [5:0]    rules_d [NE];
  logic [EW-1:0] ent_q, ent_d;
  logic [1:0]    fld_q, fld_d;
  logic          full_q, full_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [AW-1:0] head_q, head_d;
  logic [SW-1:0] cur_q, cur_d;
  logic          sym_q, sym_d;
  logic          done_q, done_d;
  logic          next_prev_q;
  logic [AW-1:0] tape_addr_q, tape_addr_d;
  logic          tape_we_q, tape_we_d;
  logic          tape_wdata_q, tape_wdata_d;
  logic          busy_q, busy_d;
  logic          step_req;
  logic [5:0]    rule_sel;

  // Next-state, rule-table and registered-output computation
  always_comb begin
    state_d  = state_q;
    rules_d  = rules_q;
    ent_d    = ent_q;
    fld_d    = fld_q;
    full_d   = full_q;
    clr_d    = clr_q;
    head_d   = head_q;
    cur_d    = cur_q;
    sym_d    = sym_q;
    done_d   = done_q;
    step_req = Next & ~next_prev_q;
    rule_sel = rules_q[{cur_q, sym_q}];

    case (state_q)
      ST_LOAD: begin
        // Done has priority: a coincident press is discarded
        if (Done) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end else if (step_req && !full_q) begin
          case (fld_q)
            2'd0:    rules_d[ent_q][5]   = input_data[0];
            2'd1:    rules_d[ent_q][4]   = input_data[0];
            default: rules_d[ent_q][3:0] = input_data;
          endcase
          if (fld_q == 2'd2) begin
            fld_d = 2'd0;
            if (ent_q == EW'(NE - 1)) full_d = 1'b1;
            else                      ent_d  = ent_q + 1'b1;
          end else begin
            fld_d = fld_q + 2'd1;
          end
        end
      end
      ST_CLEAR: begin
        if (clr_q == AW'(TAPE_LEN - 1)) begin
          state_d = ST_RUN;
          head_d  = '0;
          cur_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (step_req) state_d = ST_READ;
      end
      ST_READ: begin
        sym_d   = tape_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (rule_sel[4]) head_d = (head_q == AW'(TAPE_LEN - 1)) ? '0 : head_q + 1'b1;
        else             head_d = (head_q == '0) ? AW'(TAPE_LEN - 1) : head_q - 1'b1;
        // An out-of-range next state halts the machine; the current state is kept
        if ({28'd0, rule_sel[3:0]} >= 32'(NUM_STATES)) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end else begin
          cur_d   = SW'(rule_sel[3:0]);
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase

    // Outputs are derived from the upcoming state so they line up with it
    tape_we_d    = (state_d == ST_CLEAR) || (state_d == ST_EXEC);
    tape_addr_d  = (state_d == ST_CLEAR) ? clr_d : head_d;
    tape_wdata_d = (state_d == ST_EXEC) ? rules_q[{cur_d, sym_d}][5] : 1'b0;
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_READ) || (state_d == ST_EXEC);
  end

  // State, rule table and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      for (int i = 0; i < NE; i++) rules_q[i] <= RULE_RST;
      ent_q        <= '0;
      fld_q        <= '0;
      full_q       <= 1'b0;
      clr_q        <= '0;
      head_q       <= '0;
      cur_q        <= '0;
      sym_q        <= 1'b0;
      done_q       <= 1'b0;
      next_prev_q  <= 1'b0;
      tape_addr_q  <= '0;
      tape_we_q    <= 1'b0;
      tape_wdata_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rules_q      <= rules_d;
      ent_q        <= ent_d;
      fld_q        <= fld_d;
      full_q       <= full_d;
      clr_q        <= clr_d;
      head_q       <= head_d;
      cur_q        <= cur_d;
      sym_q        <= sym_d;
      done_q       <= done_d;
      next_prev_q  <= Next;
      tape_addr_q  <= tape_addr_d;
      tape_we_q    <= tape_we_d;
      tape_wdata_q <= tape_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign tape_addr    = tape_addr_q;
  assign tape_we      = tape_we_q;
  assign tape_wdata   = tape_wdata_q;
  assign cur_state    = cur_q;
  assign head_pos     = head_q;
  assign busy         = busy_q;
  assign Compute_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tm_controller
//  Description : Directed self-checking bench for tm_controller with a
//                behavioural 64-cell tape.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tm_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] input_data;
  logic       Next;
  logic       Done;
  logic       tape_rdata;
  logic [5:0] tape_addr;
  logic       tape_we;
  logic       tape_wdata;
  logic [1:0] cur_state;
  logic [5:0] head_pos;
  logic       busy;
  logic       Compute_done;

  int errors = 0;
  int checks = 0;

  logic tape [64];

  tm_controller #(.NUM_STATES(4), .TAPE_LEN(64)) dut (
    .clock(clock), .reset(reset), .input_data(input_data), .Next(Next),
    .Done(Done), .tape_rdata(tape_rdata), .tape_addr(tape_addr),
    .tape_we(tape_we), .tape_wdata(tape_wdata), .cur_state(cur_state),
    .head_pos(head_pos), .busy(busy), .Compute_done(Compute_done)
  );

  always #5 clock = ~clock;

  // Tape model: filled with ones during reset so that clearing is observable
  assign tape_rdata = tape[tape_addr];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) tape[i] <= 1'b1;
    end else if (tape_we) begin
      tape[tape_addr] <= tape_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; Next = 1'b0; Done = 1'b0; input_data = 4'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic load_field(input logic [3:0] v);
    input_data = v; Next = 1'b1; tick();
    Next = 1'b0; tick();
  endtask

  task automatic load_entry(input logic [3:0] w, input logic [3:0] m, input logic [3:0] n);
    load_field(w); load_field(m); load_field(n);
  endtask

  // Pulse Done, then follow CLEAR counting write strobes and address order
  task automatic run_clear(input bit poke, output int we_cnt, output bit addr_ok);
    Done = 1'b1; tick(); Done = 1'b0;
    we_cnt = 0; addr_ok = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      if (tape_we) begin
        if (tape_addr != 6'(we_cnt)) addr_ok = 1'b0;
        we_cnt++;
      end
      if (poke && i == 10) Next = 1'b1;
      if (poke && i == 11) Next = 1'b0;
      tick();
    end
    check("clear_finished", {31'd0, busy}, 32'd0);
  endtask

  task automatic step();
    Next = 1'b1; tick();
    Next = 1'b0; tick(); tick();
  endtask

  int cnt;
  bit aok;
  int ones;

  initial begin
    // ---- reset values and full-tape clear ----
    do_reset();
    check("rst_tape_addr", {26'd0, tape_addr}, 32'd0);
    check("rst_tape_we", {31'd0, tape_we}, 32'd0);
    check("rst_tape_wdata", {31'd0, tape_wdata}, 32'd0);
    check("rst_cur_state", {30'd0, cur_state}, 32'd0);
    check("rst_head_pos", {26'd0, head_pos}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_compute_done", {31'd0, Compute_done}, 32'd0);
    run_clear(1'b1, cnt, aok);
    check("clear_we_cycles", cnt, 32'd64);
    check("clear_addr_order", {31'd0, aok}, 32'd1);
    ones = 0;
    for (int i = 0; i < 64; i++) if (tape[i]) ones++;
    check("clear_tape_zero", ones, 32'd0);
    tick(); tick();
    check("clear_next_dropped", {31'd0, busy}, 32'd0);
    check("run_head_zero", {26'd0, head_pos}, 32'd0);

    // ---- write-right rule, three steps ----
    do_reset();
    load_entry(4'h1, 4'h1, 4'h0);
    run_clear(1'b0, cnt, aok);
    Next = 1'b1; tick();
    check("read_busy", {31'd0, busy}, 32'd1);
    check("read_no_we", {31'd0, tape_we}, 32'd0);
    Next = 1'b0; tick();
    check("exec_we", {31'd0, tape_we}, 32'd1);
    check("exec_wdata", {31'd0, tape_wdata}, 32'd1);
    tick();
    step(); step();
    check("s2_tape0", {31'd0, tape[0]}, 32'd1);
    check("s2_tape1", {31'd0, tape[1]}, 32'd1);
    check("s2_tape2", {31'd0, tape[2]}, 32'd1);
    check("s2_tape3", {31'd0, tape[3]}, 32'd0);
    check("s2_head", {26'd0, head_pos}, 32'd3);
    check("s2_state", {30'd0, cur_state}, 32'd0);
    check("s2_done", {31'd0, Compute_done}, 32'd0);

    // ---- left wrap then halt via state 1 ----
    do_reset();
    load_entry(4'h1, 4'h0, 4'h1);
    load_entry(4'h0, 4'h0, 4'hF);
    load_entry(4'h0, 4'h1, 4'hF);
    run_clear(1'b0, cnt, aok);
    step();
    check("s3_head_wrap", {26'd0, head_pos}, 32'd63);
    check("s3_state1", {30'd0, cur_state}, 32'd1);
    check("s3_tape0", {31'd0, tape[0]}, 32'd1);
    check("s3_not_done", {31'd0, Compute_done}, 32'd0);
    step();
    check("s3_head_back", {26'd0, head_pos}, 32'd0);
    check("s3_state_held", {30'd0, cur_state}, 32'd1);
    check("s3_done", {31'd0, Compute_done}, 32'd1);
    check("s3_tape63", {31'd0, tape[63]}, 32'd0);
    step();
    check("s3_halt_head", {26'd0, head_pos}, 32'd0);
    check("s3_halt_busy", {31'd0, busy}, 32'd0);
    check("s3_halt_done", {31'd0, Compute_done}, 32'd1);

    // ---- held Next and press during EXEC ----
    do_reset();
    load_entry(4'h1, 4'h1, 4'h0);
    run_clear(1'b0, cnt, aok);
    cnt = 0;
    Next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tape_we) cnt++;
    end
    Next = 1'b0; tick(); tick();
    check("held_exec_count", cnt, 32'd1);
    check("held_head", {26'd0, head_pos}, 32'd1);
    Next = 1'b1; tick();
    Next = 1'b0; tick();
    check("exec_phase_we", {31'd0, tape_we}, 32'd1);
    Next = 1'b1; tick();
    Next = 1'b0; tick(); tick(); tick();
    check("exec_press_dropped", {26'd0, head_pos}, 32'd2);
    check("exec_press_idle", {31'd0, busy}, 32'd0);

    // ---- Done and Next together in LOAD ----
    do_reset();
    input_data = 4'h1; Done = 1'b1; Next = 1'b1; tick();
    Done = 1'b0; Next = 1'b0;
    check("dn_clear_we", {31'd0, tape_we}, 32'd1);
    check("dn_clear_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 200 && busy; i++) tick();
    step();
    check("dn_default_head", {26'd0, head_pos}, 32'd63);
    check("dn_default_done", {31'd0, Compute_done}, 32'd1);
    check("dn_no_capture", {31'd0, tape[0]}, 32'd0);

    // ---- reset in the middle of CLEAR ----
    do_reset();
    load_entry(4'h1, 4'h1, 4'h0);
    Done = 1'b1; tick(); Done = 1'b0;
    repeat (20) tick();
    check("mid_clear_addr", {26'd0, tape_addr}, 32'd20);
    reset = 1'b1; tick();
    check("mid_rst_we", {31'd0, tape_we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {26'd0, tape_addr}, 32'd0);
    reset = 1'b0;
    run_clear(1'b0, cnt, aok);
    check("mid_rst_clear_cycles", cnt, 32'd64);
    step();
    check("mid_rst_rules_head", {26'd0, head_pos}, 32'd63);
    check("mid_rst_rules_done", {31'd0, Compute_done}, 32'd1);
    check("mid_rst_rules_tape0", {31'd0, tape[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
